led_matrix_spi_receiver: RTL and testbench

SPI peripheral-side receiver for the 8x8 LED matrix link: samples `sclk`/`mosi`/`n_cs` from the matrix driver, deserialises bytes MSB-first and decodes the frame protocol. The reset-frame-index command byte (0x26) is recognised, and pixel bytes are delivered with their 0..63 index through a one-entry valid/ready holding register. It sits at the matrix end of the link and feeds a frame buffer or pixel sink.

---
 rtl/led_matrix_pkg.sv | 19 +
 rtl/spi_input_sync.sv | 46 ++++
 rtl/led_matrix_spi_receiver.sv | 118 +++++++++++
 tb/tb_led_matrix_spi_receiver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared definitions for the 8x8 LED matrix SPI link (driver and receiver side).
package led_matrix_pkg;
  localparam logic [7:0] CMD_RESET_FRAME_INDEX = 8'h26;
  localparam int         PIXEL_COUNT           = 64;
  localparam int         PIXEL_INDEX_W         = 6;
  localparam int         RGB_R_W               = 3;
  localparam int         RGB_G_W               = 3;
  localparam int         RGB_B_W               = 2;

  typedef logic [PIXEL_INDEX_W-1:0] pixel_index_t;

  typedef struct packed {
    logic [RGB_R_W-1:0] r;
    logic [RGB_G_W-1:0] g;
    logic [RGB_B_W-1:0] b;
  } rgb332_t;

  localparam pixel_index_t LAST_PIXEL_INDEX = pixel_index_t'(PIXEL_COUNT - 1);
endpackage

// File: rtl/spi_input_sync.sv
// Synchronises sclk/mosi/n_cs into the system clock domain and flags sclk rising edges.
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sclk,
  input  logic mosi,
  input  logic n_cs,
  output logic sclk_rise,
  output logic mosi_s,
  output logic n_cs_s
);
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic                   sclk_prev_q;
  logic                   rise_q;
  logic                   mosi_q;
  logic                   ncs_q;

  // Edge flag is registered; mosi and n_cs get one matching stage so all three stay aligned.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ncs_q       <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], n_cs};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      rise_q      <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
      mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
      ncs_q       <= ncs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = rise_q;
  assign mosi_s    = mosi_q;
  assign n_cs_s    = ncs_q;
endmodule

// File: rtl/led_matrix_spi_receiver.sv
// LED matrix SPI receiver: byte deserialiser, frame command decode and one-entry pixel holding register.
import led_matrix_pkg::*;

module led_matrix_spi_receiver #(
  parameter int         SYNC_STAGES           = 2,
  parameter logic [7:0] CMD_RESET_FRAME_INDEX = led_matrix_pkg::CMD_RESET_FRAME_INDEX
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     sclk,
  input  logic                     mosi,
  input  logic                     n_cs,
  output logic                     pixel_valid,
  input  logic                     pixel_ready,
  output logic [7:0]               pixel_data,
  output logic [PIXEL_INDEX_W-1:0] pixel_index,
  output logic                     frame_start,
  output logic                     frame_done,
  output logic                     overrun
);
  logic         sclk_rise, mosi_s, n_cs_s;
  logic [6:0]   shift_q, shift_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic         first_q, first_d;
  pixel_index_t widx_q, widx_d;
  logic         valid_q, valid_d;
  rgb332_t      data_q, data_d;
  pixel_index_t index_q, index_d;
  logic         fs_q, fs_d;
  logic         fd_q, fd_d;
  logic         ovr_q, ovr_d;
  logic [7:0]   rx_byte;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock     (clock),
    .reset     (reset),
    .sclk      (sclk),
    .mosi      (mosi),
    .n_cs      (n_cs),
    .sclk_rise (sclk_rise),
    .mosi_s    (mosi_s),
    .n_cs_s    (n_cs_s)
  );

  assign rx_byte = {shift_q, mosi_s};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      first_q   <= 1'b1;
      widx_q    <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      index_q   <= '0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      first_q   <= first_d;
      widx_q    <= widx_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      index_q   <= index_d;
      fs_q      <= fs_d;
      fd_q      <= fd_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    first_d   = first_q;
    widx_d    = widx_q;
    valid_d   = valid_q;
    data_d    = data_q;
    index_d   = index_q;
    fs_d      = 1'b0;
    fd_d      = 1'b0;
    ovr_d     = ovr_q;
    if (valid_q && pixel_ready) valid_d = 1'b0;
    // Deselect abandons any partial byte; the next byte is a command candidate again.
    if (n_cs_s) begin
      bit_cnt_d = '0;
      first_d   = 1'b1;
    end else if (sclk_rise) begin
      shift_d   = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        first_d = 1'b0;
        if (first_q && (rx_byte == CMD_RESET_FRAME_INDEX)) begin
          widx_d = '0;
          fs_d   = 1'b1;
        end else begin
          widx_d = widx_q + pixel_index_t'(1);
          if (!valid_q || pixel_ready) begin
            valid_d = 1'b1;
            data_d  = rgb332_t'(rx_byte);
            index_d = widx_q;
            fd_d    = (widx_q == LAST_PIXEL_INDEX);
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
    end
  end

  assign pixel_valid = valid_q;
  assign pixel_data  = data_q;
  assign pixel_index = index_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign overrun     = ovr_q;
endmodule

// File: tb/tb_led_matrix_spi_receiver.sv
// Directed bench for led_matrix_spi_receiver: drives SPI transactions and logs accepted pixels and pulses.
module tb_led_matrix_spi_receiver;
  logic       clock = 1'b0;
  logic       reset, sclk, mosi, n_cs, pixel_ready;
  logic       pixel_valid, frame_start, frame_done, overrun;
  logic [7:0] pixel_data;
  logic [5:0] pixel_index;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_rise = 0;
  int fs_cnt = 0, fd_cnt = 0, both_cnt = 0, fs_cyc = 0, fd_idx = 0;
  logic [13:0] q[$];

  led_matrix_spi_receiver dut (
    .clock       (clock),
    .reset       (reset),
    .sclk        (sclk),
    .mosi        (mosi),
    .n_cs        (n_cs),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .pixel_data  (pixel_data),
    .pixel_index (pixel_index),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (pixel_valid && pixel_ready) q.push_back({pixel_index, pixel_data});
    if (frame_start) begin fs_cnt++; fs_cyc = cyc; end
    if (frame_done) begin fd_cnt++; fd_idx = int'(pixel_index); end
    if (frame_start && frame_done) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic spi_bit(input logic b);
    @(negedge clock) mosi = b;
    repeat (3) @(negedge clock);
    sclk = 1'b1;
    last_rise = cyc;
    repeat (3) @(negedge clock);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_begin();
    @(negedge clock) n_cs = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic cs_end();
    repeat (8) @(negedge clock);
    n_cs = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clock);
    #2 pixel_ready = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(pixel_valid), 0);
    check({tag, "_data"},  32'(pixel_data),  0);
    check({tag, "_index"}, 32'(pixel_index), 0);
    check({tag, "_fs"},    32'(frame_start), 0);
    check({tag, "_fd"},    32'(frame_done),  0);
    check({tag, "_ovr"},   32'(overrun),     0);
  endtask

  initial begin
    int fs0, fd0, bad;
    logic [7:0] d;
    reset = 1'b1; sclk = 1'b0; mosi = 1'b0; n_cs = 1'b1; pixel_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b0;
    set_ready(1'b1);

    // Command then a full 64-pixel frame
    fs0 = fs_cnt; fd0 = fd_cnt;
    cs_begin(); spi_byte(8'h26); cs_end();
    check("t1_fs_count", 32'(fs_cnt - fs0), 1);
    check("t1_fs_latency", 32'(fs_cyc - last_rise), 4);
    q.delete();
    cs_begin();
    for (int i = 0; i < 64; i++) spi_byte(8'(i));
    cs_end();
    check("t1_pixel_count", 32'(q.size()), 64);
    bad = 0;
    for (int i = 0; i < q.size(); i++)
      if (q[i] !== {6'(i), 8'(i)}) bad++;
    check("t1_pixel_entries_bad", 32'(bad), 0);
    check("t1_fs_count_after", 32'(fs_cnt - fs0), 1);
    check("t1_fd_count", 32'(fd_cnt - fd0), 1);
    check("t1_fd_index", 32'(fd_idx), 63);
    check("t1_overrun", 32'(overrun), 0);

    // 0x26 in 5th position is a pixel
    fs0 = fs_cnt; q.delete();
    cs_begin();
    spi_byte(8'h10); spi_byte(8'h11); spi_byte(8'h12); spi_byte(8'h13);
    spi_byte(8'h26); spi_byte(8'h27);
    cs_end();
    check("t2_pixel_count", 32'(q.size()), 6);
    if (q.size() >= 6) begin
      check("t2_first_pixel", 32'(q[0]), 32'({6'd0, 8'h10}));
      check("t2_cmd_as_pixel", 32'(q[4]), 32'({6'd4, 8'h26}));
    end
    check("t2_no_fs", 32'(fs_cnt - fs0), 0);

    // Backpressure: second byte dropped
    cs_begin(); spi_byte(8'h26); cs_end();
    set_ready(1'b0);
    q.delete();
    cs_begin(); spi_byte(8'hA5); spi_byte(8'h5A); cs_end();
    check("t3_valid_held", 32'(pixel_valid), 1);
    check("t3_data_held", 32'(pixel_data), 32'h A5);
    check("t3_index_held", 32'(pixel_index), 0);
    check("t3_overrun", 32'(overrun), 1);
    check("t3_none_accepted", 32'(q.size()), 0);
    set_ready(1'b1);
    repeat (3) @(negedge clock);
    check("t3_valid_drained", 32'(pixel_valid), 0);
    cs_begin(); spi_byte(8'h77); cs_end();
    check("t3_pixel_count", 32'(q.size()), 2);
    if (q.size() >= 2) begin
      check("t3_a5_delivered", 32'(q[0]), 32'({6'd0, 8'hA5}));
      check("t3_next_index2", 32'(q[1]), 32'({6'd2, 8'h77}));
    end
    check("t3_overrun_sticky", 32'(overrun), 1);

    // CS raised after 5 bits
    fs0 = fs_cnt; q.delete();
    cs_begin();
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
    cs_end();
    cs_begin(); spi_byte(8'h26); spi_byte(8'hE0); cs_end();
    check("t4_fs_count", 32'(fs_cnt - fs0), 1);
    check("t4_pixel_count", 32'(q.size()), 1);
    if (q.size() >= 1) check("t4_e0_at_0", 32'(q[0]), 32'({6'd0, 8'hE0}));

    // 65 pixels: index wraps, frame_done after the 64th
    cs_begin(); spi_byte(8'h26); cs_end();
    fs0 = fs_cnt; fd0 = fd_cnt; q.delete();
    cs_begin();
    for (int i = 0; i < 65; i++) spi_byte(8'(i * 3));
    cs_end();
    check("t5_pixel_count", 32'(q.size()), 65);
    bad = 0;
    for (int i = 0; i < q.size(); i++) begin
      d = 8'(i * 3);
      if (q[i] !== {6'(i % 64), d}) bad++;
    end
    check("t5_pixel_entries_bad", 32'(bad), 0);
    if (q.size() >= 65) check("t5_65th_index", 32'(q[64][13:8]), 0);
    check("t5_fd_count", 32'(fd_cnt - fd0), 1);
    check("t5_fd_index", 32'(fd_idx), 63);
    check("t5_no_fs", 32'(fs_cnt - fs0), 0);

    // Async reset mid-byte
    set_ready(1'b0);
    cs_begin();
    spi_byte(8'h5C);
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    check("t6_pre_valid", 32'(pixel_valid), 1);
    check("t6_pre_overrun", 32'(overrun), 1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_reset_outputs("t6_rst");
    @(negedge clock) reset = 1'b0;
    set_ready(1'b1);
    fs0 = fs_cnt; q.delete();
    repeat (4) @(negedge clock);
    spi_byte(8'h26); spi_byte(8'h33);
    cs_end();
    check("t6_fs_count", 32'(fs_cnt - fs0), 1);
    check("t6_pixel_count", 32'(q.size()), 1);
    if (q.size() >= 1) check("t6_33_at_0", 32'(q[0]), 32'({6'd0, 8'h33}));

    check("fs_fd_same_cycle", 32'(both_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
